// File: rtl/rf_dump_pkg.sv
// Shared types and default sizes for the register-file debug dump path.
// Also used by the register file and the display logic.
package rf_dump_pkg;

  localparam int DEF_NREGS  = 32;
  localparam int DEF_SEL_W  = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/rf_dump_scanner.sv
// Walks the register file debug port and streams each register value
// with its index over a valid/ready handshake.
module rf_dump_scanner
  import rf_dump_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  output logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] last_idx;

  assign last_idx = SEL_W'(NREGS - 1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: begin
        state_d = abort ? IDLE : SEND;
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          if (out_last) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cont) begin
          state_d = FETCH;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Each word is sampled in its own FETCH cycle, not as a snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else if (state_q == FETCH) begin
      out_data <= reg_data;
      out_idx  <= idx_q;
      out_last <= (idx_q == last_idx);
    end
  end

  assign reg_sel   = (state_q == FETCH) ? idx_q : '0;
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_rf_dump_scanner.sv
// Self-checking bench for rf_dump_scanner: table-driven first dump,
// hand-written corner sequences and randomized dumps against a model.
module tb_rf_dump_scanner;

  localparam int NREGS  = 32;
  localparam int SEL_W  = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              cont = 1'b0;
  logic              abort = 1'b0;
  logic [SEL_W-1:0]  reg_sel;
  logic [DATA_W-1:0] reg_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_idx;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] rf [NREGS];
  int edges = 0;
  int vecs = 0;
  int miss = 0;

  // hooks acted on by run_dump when word k is first seen valid
  int wr_at = -1;
  int wr_reg = 0;
  logic [DATA_W-1:0] wr_val = '0;
  int cont_clr_at = -1;
  int start_at = -1;

  typedef struct {
    int                stall;
    logic [SEL_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } vec_t;
  vec_t tbl [NREGS];

  rf_dump_scanner dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .reg_sel(reg_sel), .reg_data(reg_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  always_comb begin
    reg_data = '0;
    if (reg_sel != '0) reg_data = rf[reg_sel];
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic preload();
    rf[0] = '0;
    for (int i = 1; i < NREGS; i++) rf[i] = 32'h100 + i;
  endtask

  task automatic wait_valid(input int bound);
    int g = 0;
    while (!out_valid && g < bound) begin
      @(negedge clk);
      g++;
    end
  endtask

  // One dump with random backpressure; expected data is the register value
  // as of the word's fetch, tracked by applying hook writes to later words.
  task automatic run_dump(input bit do_start, input int pct,
                          output int w0e, output int de);
    logic [DATA_W-1:0] mdl [NREGS];
    bit acc;
    int stalls;
    w0e = -1;
    de = -1;
    for (int i = 0; i < NREGS; i++) mdl[i] = rf[i];
    mdl[0] = '0;
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < NREGS; k++) begin
      wait_valid(4);
      check("valid_wait", 32'(out_valid), 32'd1);
      if (!out_valid) return;
      if (k == 0) w0e = edges;
      if (pct == 100) check("word_time", 32'(edges - w0e), 32'(2 * k));
      if (k == wr_at) begin
        rf[wr_reg] = wr_val;
        if (wr_reg > k) mdl[wr_reg] = wr_val;
      end
      if (k == cont_clr_at) cont = 1'b0;
      if (k == start_at) start = 1'b1;
      acc = 1'b0;
      stalls = 0;
      while (!acc) begin
        check("rnd_valid", 32'(out_valid), 32'd1);
        check("rnd_idx", 32'(out_idx), 32'(k));
        check("rnd_data", out_data, mdl[k]);
        check("rnd_last", 32'(out_last), 32'(k == NREGS - 1));
        out_ready = ($urandom_range(99) < pct) || (stalls > 20);
        acc = out_ready;
        stalls++;
        @(negedge clk);
        start = 1'b0;
      end
      out_ready = 1'b1;
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_novalid", 32'(out_valid), 32'd0);
    de = edges;
  endtask

  initial begin
    int s, stalls, w0e, de, w0e2, de2;
    bit bad;

    for (int i = 0; i < NREGS; i++) begin
      tbl[i].stall = (i == 3) ? 5 : 0;
      tbl[i].idx   = SEL_W'(i);
      tbl[i].data  = (i == 0) ? 32'h0 : 32'h100 + i;
      tbl[i].last  = (i == NREGS - 1);
    end
    preload();

    // reset state
    #2;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_data", out_data, 0);
    check("rst_sel", 32'(reg_sel), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // table-driven first dump with a 5-cycle stall on idx 3
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = edges;
    check("fetch_busy", 32'(busy), 1);
    check("fetch_novalid", 32'(out_valid), 0);
    stalls = 0;
    for (int i = 0; i < NREGS; i++) begin
      wait_valid(4);
      check("tbl_time", 32'(edges), 32'(s + 1 + 2 * i + stalls));
      check("tbl_idx", 32'(out_idx), 32'(tbl[i].idx));
      check("tbl_data", out_data, tbl[i].data);
      check("tbl_last", 32'(out_last), 32'(tbl[i].last));
      if (tbl[i].stall > 0) begin
        out_ready = 1'b0;
        repeat (tbl[i].stall) begin
          @(negedge clk);
          check("hold_valid", 32'(out_valid), 1);
          check("hold_idx", 32'(out_idx), 32'(tbl[i].idx));
          check("hold_data", out_data, tbl[i].data);
        end
        stalls += tbl[i].stall;
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("tbl_done", 32'(done), 1);
    check("tbl_done_time", 32'(edges), 32'(s + 64 + stalls));
    @(negedge clk);
    check("tbl_idle_busy", 32'(busy), 0);
    check("tbl_idle_done", 32'(done), 0);

    // x7 written before its fetch is seen
    wr_at = 5; wr_reg = 7; wr_val = 32'hDEAD;
    run_dump(1'b1, 100, w0e, de);
    check("full_period", 32'(de - w0e), 32'd63);
    @(negedge clk);
    preload();

    // x7 written after its fetch is not seen
    wr_at = 7; wr_reg = 7; wr_val = 32'hDEAD;
    run_dump(1'b1, 100, w0e, de);
    wr_at = -1;
    @(negedge clk);
    preload();

    // start while busy is ignored
    start_at = 5;
    run_dump(1'b1, 100, w0e, de);
    start_at = -1;
    @(negedge clk);
    check("nostart_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    check("nostart_idle", 32'(busy), 0);

    // abort in SEND at idx 10 with ready high, start in the same cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 100 && !(out_valid && out_idx == 10); g++)
      @(negedge clk);
    check("abort_reach", 32'(out_valid && out_idx == 10), 1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_valid", 32'(out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    bad = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (done || out_valid || busy) bad = 1'b1;
    end
    check("abort_quiet", 32'(bad), 0);

    // continuous mode: back-to-back dumps, cont dropped mid-second
    cont = 1'b1;
    run_dump(1'b1, 100, w0e, de);
    @(negedge clk);
    check("cont_fetch_busy", 32'(busy), 1);
    check("cont_fetch_sel", 32'(reg_sel), 0);
    check("cont_fetch_nv", 32'(out_valid), 0);
    cont_clr_at = 15;
    run_dump(1'b0, 100, w0e2, de2);
    cont_clr_at = -1;
    check("cont_w0_time", 32'(w0e2 - de), 32'd2);
    check("cont_period", 32'(de2 - de), 32'd65);
    @(negedge clk);
    check("cont_end_idle", 32'(busy), 0);
    cont = 1'b0;

    // asynchronous reset in SEND at idx 20
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 100 && !(out_valid && out_idx == 20); g++)
      @(negedge clk);
    check("rst_reach", 32'(out_valid && out_idx == 20), 1);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_data", out_data, 0);
    check("arst_idx", 32'(out_idx), 0);
    check("arst_last", 32'(out_last), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_dump(1'b1, 100, w0e, de);
    @(negedge clk);

    // randomized contents, backpressure and mid-dump writes
    for (int r = 0; r < 4; r++) begin
      for (int i = 1; i < NREGS; i++) rf[i] = $urandom;
      wr_at = $urandom_range(NREGS - 1);
      wr_reg = $urandom_range(NREGS - 1, 1);
      wr_val = $urandom;
      run_dump(1'b1, 50 + 10 * r, w0e, de);
      @(negedge clk);
      check("rnd_idle", 32'(busy), 0);
    end
    wr_at = -1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_dump_scanner.md
# rf_dump_scanner

Debug read-out engine for the pipelined CPU's 32×32 register file. It drives the register file's debug select port (`reg_sel`) and samples its combinational debug data (`reg_data`). On request, it walks registers x0..x31 and streams each value with its index over a valid/ready handshake toward the board display / trace path. It can run once per `start` or continuously for live display refresh.

## Interface
- `NREGS`, 32: number of registers scanned, indices 0..NREGS-1.
- `SEL_W`, 5: select width; `NREGS` ≤ 2^`SEL_W`.
- `DATA_W`, 32: register width.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request to begin a dump; ignored while `busy`.
- `cont` in 1: level; when high at the end of a dump, a new dump begins immediately.
- `abort` in 1: synchronous cancel; has priority over `start`.
- `reg_sel` out `SEL_W`: register index presented to the register file.
- `reg_data` in `DATA_W`: register file debug data for `reg_sel`; combinational, same cycle.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: consumer accepts the word when `out_valid` and `out_ready` are both high.
- `out_data` out `DATA_W`: sampled register value.
- `out_idx` out `SEL_W`: index of `out_data`.
- `out_last` out 1: high with the word for index `NREGS-1`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last word is accepted.

## Operation
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - `reg_sel`=0, `out_valid`=0.
  - `start` && !`abort` → FETCH, index counter cleared to 0.
- FETCH:
  - `reg_sel`=index.
  - At the clock edge, `reg_data` is latched into `out_data`, index into `out_idx`, and (index==`NREGS-1`) into `out_last`.
  - → SEND.
- SEND:
  - `out_valid`=1.
  - While `out_ready`=0, `out_data`/`out_idx`/`out_last` are held stable and `out_valid` stays high; it cannot drop except on `abort` or `rst`.
  - On accept: if `out_last`, → DONE; else index+1 → FETCH.
- DONE:
  - `done`=1 for this single cycle.
  - If `cont`=1, → FETCH with index 0; else → IDLE.
- x0 is scanned like any other register. The value is whatever the register file returns (0).
- Values are sampled per word at FETCH time, not as an atomic snapshot. A write-back to register k before k's FETCH cycle is visible in the dump; a write after it is not.
- `abort` in any state → IDLE next edge: `out_valid`=0, `busy`=0, no `done` pulse. A word in SEND is dropped even if `out_ready` is high in the same cycle.
- `start` in any state other than IDLE: ignored, not queued.
- `cont` sampled only in DONE. Dropping it mid-dump lets the current dump complete.

## Timing
- Reset values: `reg_sel`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `busy`=0, `done`=0, state IDLE, index 0.
- `start` high at edge N:
  - FETCH during cycle N+1 (`busy`=1).
  - First `out_valid` during cycle N+2.
- Each word costs 2 cycles minimum (FETCH + SEND). With `out_ready` tied high:
  - word k valid in cycle N+2+2k;
  - last word in cycle N+64;
  - `done` in cycle N+65;
  - `busy` low in cycle N+66 (cont=0).
- Continuous mode: the DONE cycle is followed directly by FETCH of x0, for a 65-cycle dump period with `out_ready` high.
- Index counter width `SEL_W`. It wraps to 0 only via the DONE → FETCH transition, never by overflow.
- Reset mid-operation: all outputs return to reset values asynchronously; no partial `done`.

## Structure
- Package `rf_dump_pkg`:
  - state enum (IDLE, FETCH, SEND, DONE);
  - default `NREGS`/`SEL_W`/`DATA_W` constants, shared with the register file and display logic.
- Single module; no sub-module. The FSM, index counter and output holding register together fit in one block of about 150 lines.

## Test plan
- Preload x1..x31 = 0x100+i. Pulse `start` with `out_ready`=1. Expect 32 words idx 0..31, data 0 then 0x101..0x11F; `out_last` only on idx 31; `done` at cycle N+65.
- Backpressure: `out_ready` low for 5 cycles on idx 3. Expect `out_valid` high and `out_data`=0x103, `out_idx`=3 stable throughout; idx 4 follows 2 cycles after the accept.
- Write x7=0xDEAD during the dump, before vs. after idx 7's FETCH cycle. Expect 0xDEAD vs. 0x107 respectively.
- `abort` while in SEND at idx 10 with `out_ready`=1. Expect no further words, `busy`=0 next cycle, no `done`. A `start` in the same cycle as `abort` is also ignored.
- `cont`=1. Expect x0 to be FETCHed the cycle after `done`, two full dumps back to back with a 65-cycle period; clear `cont` mid-second-dump and expect the second dump to complete, then IDLE.
- Assert `rst` at idx 20 in SEND. Expect all outputs 0 immediately. `start` after reset release begins at idx 0.
